// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - MIPS F/D/E/M/W hazard unit with private Tnew scoreboard and HI/LO occupancy counter
// Optional HAZ_PERF_CNT_EN adds free-running stall performance counters.
module hazard_scoreboard #(
   parameter int NSRC    = 2,
   parameter int NSTAGE  = 3,
   parameter int AW      = 5,
   parameter int TW      = 2,
   parameter int SW      = 2,
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NSRC*AW-1:0]   d_src_addr,
   input  logic [NSRC*TW-1:0]   d_src_tuse,
   input  logic [AW-1:0]        d_dst_addr,
   input  logic [TW-1:0]        d_tnew,
   input  logic                 d_md_use,
   input  logic                 d_md_start,
   input  logic                 d_md_is_div,
   input  logic                 ext_flush,
   output logic                 stall_f,
   output logic                 stall_d,
   output logic                 flush_e,
   output logic [NSRC*SW-1:0]   fwd_d,
   output logic [NSRC*SW-1:0]   fwd_e,
   output logic                 md_busy,
   output logic [31:0]          perf_stall,
   output logic [31:0]          perf_md
);

   localparam int MAXLAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
   localparam int CW     = $clog2(MAXLAT + 1);

   logic [AW-1:0] r_slot_addr [NSTAGE];
   logic [TW-1:0] r_slot_tnew [NSTAGE];
   logic [AW-1:0] r_esrc      [NSRC];
   logic [CW-1:0] r_md_cnt;

   logic [NSRC-1:0] w_stall_src;
   logic            w_md_stall;
   logic            w_stall;
   logic [AW-1:0]   w_src;
   logic [TW-1:0]   w_tuse;
   logic            w_hit;
   logic [TW-1:0]   w_hit_tnew;
   logic [SW-1:0]   w_hit_idx;

   // Slots are scanned oldest-first so the youngest match overwrites the winner.
   always_comb begin
      w_stall_src = '0;
      fwd_d       = '0;
      fwd_e       = '0;
      w_src       = '0;
      w_tuse      = '0;
      w_hit       = 1'b0;
      w_hit_tnew  = '0;
      w_hit_idx   = '0;
      for (int i = 0; i < NSRC; i++) begin
         w_src      = d_src_addr[i*AW +: AW];
         w_tuse     = d_src_tuse[i*TW +: TW];
         w_hit      = 1'b0;
         w_hit_tnew = '0;
         w_hit_idx  = '0;
         for (int j = NSTAGE - 1; j >= 0; j--) begin
            if (w_src != '0 && w_src == r_slot_addr[j]) begin
               w_hit      = 1'b1;
               w_hit_tnew = r_slot_tnew[j];
               w_hit_idx  = SW'(j + 1);
            end
         end
         if (w_hit && w_hit_tnew > w_tuse)
            w_stall_src[i] = 1'b1;
         else if (w_hit && w_hit_tnew == '0)
            fwd_d[i*SW +: SW] = w_hit_idx;

         w_hit      = 1'b0;
         w_hit_tnew = '0;
         w_hit_idx  = '0;
         for (int j = NSTAGE - 1; j >= 1; j--) begin
            if (r_esrc[i] != '0 && r_esrc[i] == r_slot_addr[j]) begin
               w_hit      = 1'b1;
               w_hit_tnew = r_slot_tnew[j];
               w_hit_idx  = SW'(j + 1);
            end
         end
         if (w_hit && w_hit_tnew == '0)
            fwd_e[i*SW +: SW] = w_hit_idx;
      end
   end

   assign md_busy    = (r_md_cnt != '0);
   assign w_md_stall = d_md_use && md_busy;
   assign w_stall    = (|w_stall_src) || w_md_stall;
   assign stall_f    = w_stall;
   assign stall_d    = w_stall;
   assign flush_e    = w_stall;

   // E..W never stall: the pipeline behind D always advances.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int j = 0; j < NSTAGE; j++) begin
            r_slot_addr[j] <= '0;
            r_slot_tnew[j] <= '0;
         end
         for (int i = 0; i < NSRC; i++)
            r_esrc[i] <= '0;
      end else begin
         if (ext_flush) begin
            for (int j = 0; j < NSTAGE; j++) begin
               r_slot_addr[j] <= '0;
               r_slot_tnew[j] <= '0;
            end
         end else begin
            if (w_stall) begin
               r_slot_addr[0] <= '0;
               r_slot_tnew[0] <= '0;
            end else begin
               r_slot_addr[0] <= d_dst_addr;
               r_slot_tnew[0] <= d_tnew;
            end
            for (int j = 1; j < NSTAGE; j++) begin
               r_slot_addr[j] <= r_slot_addr[j-1];
               r_slot_tnew[j] <= (r_slot_tnew[j-1] != '0) ? r_slot_tnew[j-1] - TW'(1) : '0;
            end
         end
         for (int i = 0; i < NSRC; i++)
            r_esrc[i] <= (w_stall || ext_flush) ? '0 : d_src_addr[i*AW +: AW];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_md_cnt <= '0;
      else if (d_md_start && !w_stall)
         r_md_cnt <= d_md_is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
      else if (r_md_cnt != '0)
         r_md_cnt <= r_md_cnt - CW'(1);
   end

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_md;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_perf_stall <= '0;
         r_perf_md    <= '0;
      end else begin
         if (w_stall)
            r_perf_stall <= r_perf_stall + 32'd1;
         if (w_md_stall)
            r_perf_md <= r_perf_md + 32'd1;
      end
   end

   assign perf_stall = r_perf_stall;
   assign perf_md    = r_perf_md;
`else
   assign perf_stall = '0;
   assign perf_md    = '0;
`endif

endmodule
